// File: rtl/mvu_vvu_axis.sv
// AXI-Stream matrix-vector / vector-vector unit: folds SF activation beats against NF*SF weight
// beats and emits NF beats of PE accumulated dot products through a registered output stage.
module mvu_vvu_axis #(
  parameter int unsigned IS_MVU             = 1,
  parameter string       COMPUTE_CORE       = "mvu_4sx4u",
  parameter int unsigned MW                 = 96,
  parameter int unsigned MH                 = 32,
  parameter int unsigned SIMD               = 48,
  parameter int unsigned PE                 = 16,
  parameter int unsigned SEGMENTLEN         = 2,
  parameter int unsigned FORCE_BEHAVIORAL   = 0,
  parameter int unsigned M_REG_LUT          = 1,
  parameter int unsigned ACTIVATION_WIDTH   = 4,
  parameter int unsigned WEIGHT_WIDTH       = 4,
  parameter int unsigned ACCU_WIDTH         = 15,
  parameter int unsigned SIGNED_ACTIVATIONS = 1
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic [((PE*SIMD*WEIGHT_WIDTH+7)/8)*8-1:0]                          s_axis_weights_tdata,
  input  logic                                                               s_axis_weights_tvalid,
  output logic                                                               s_axis_weights_tready,
  input  logic [((((IS_MVU != 0) ? 1 : PE)*SIMD*ACTIVATION_WIDTH+7)/8)*8-1:0] s_axis_input_tdata,
  input  logic                                                               s_axis_input_tvalid,
  output logic                                                               s_axis_input_tready,
  output logic [((PE*ACCU_WIDTH+7)/8)*8-1:0]                                 m_axis_output_tdata,
  output logic                                                               m_axis_output_tvalid,
  input  logic                                                               m_axis_output_tready
);

  localparam int unsigned SF       = MW / SIMD;
  localparam int unsigned NF       = MH / PE;
  localparam int unsigned SF_W     = (SF > 1) ? $clog2(SF) : 1;
  localparam int unsigned NF_W     = (NF > 1) ? $clog2(NF) : 1;
  localparam int unsigned IN_LANES = ((IS_MVU != 0) ? 1 : PE) * SIMD;
  localparam int unsigned ACT_BITS = IN_LANES * ACTIVATION_WIDTH;
  localparam int unsigned BUF_BITS = SIMD * ACTIVATION_WIDTH;
  localparam int unsigned ACC_BITS = PE * ACCU_WIDTH;
  localparam int unsigned OUT_BITS = ((PE*ACCU_WIDTH+7)/8)*8;

  // Core choice and timing knobs never change numerics; an ill-formed configuration simply never fires.
  localparam bit CFG_OK = (MW % SIMD == 0) && (MH % PE == 0) && (SEGMENTLEN >= 1) &&
                          (FORCE_BEHAVIORAL <= 1) && (M_REG_LUT <= 1) && (COMPUTE_CORE != "");

  logic [NF_W-1:0]       nf;
  logic [SF_W-1:0]       sf;
  logic [BUF_BITS-1:0]   act_buf [SF];
  logic [ACT_BITS-1:0]   act;
  logic [ACC_BITS-1:0]   acc;
  logic [ACC_BITS-1:0]   acc_next;
  logic [OUT_BITS-1:0]   out_data;
  logic                  out_valid;
  logic                  use_stream;
  logic                  stall;
  logic                  fire;
  logic                  last_sf;
  logic                  last_nf;
  logic [ACTIVATION_WIDTH-1:0] a_raw;
  logic [WEIGHT_WIDTH-1:0]     w_raw;
  logic [ACCU_WIDTH-1:0]       a_ext;
  logic [ACCU_WIDTH-1:0]       w_ext;
  logic [ACCU_WIDTH-1:0]       sum;

  // Handshake: one compute step needs a weight beat, an activation source and a free output slot.
  always_comb begin
    use_stream = (IS_MVU == 0) || (nf == '0);
    stall      = out_valid && !m_axis_output_tready;
    last_sf    = (sf == SF_W'(SF - 1));
    last_nf    = (nf == NF_W'(NF - 1));
    fire       = ap_rst_n && CFG_OK && !stall && s_axis_weights_tvalid &&
                 (use_stream ? s_axis_input_tvalid : 1'b1);
    s_axis_weights_tready = fire;
    s_axis_input_tready   = fire && use_stream;
    act = use_stream ? s_axis_input_tdata[ACT_BITS-1:0] : ACT_BITS'(act_buf[sf]);
  end

  // Modulo-2^ACCU_WIDTH dot products; extending operands to the accumulator width keeps wrap exact.
  always_comb begin
    acc_next = '0;
    a_raw    = '0;
    w_raw    = '0;
    a_ext    = '0;
    w_ext    = '0;
    sum      = '0;
    for (int k = 0; k < int'(PE); k++) begin
      sum = (sf == '0) ? '0 : acc[k*ACCU_WIDTH +: ACCU_WIDTH];
      for (int l = 0; l < int'(SIMD); l++) begin
        a_raw = act[((IS_MVU != 0) ? l : k*int'(SIMD) + l)*ACTIVATION_WIDTH +: ACTIVATION_WIDTH];
        w_raw = s_axis_weights_tdata[(k*int'(SIMD) + l)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        a_ext = (SIGNED_ACTIVATIONS != 0) ? ACCU_WIDTH'($signed(a_raw)) : ACCU_WIDTH'(a_raw);
        w_ext = ACCU_WIDTH'($signed(w_raw));
        sum   = sum + a_ext * w_ext;
      end
      acc_next[k*ACCU_WIDTH +: ACCU_WIDTH] = sum;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      nf        <= '0;
      sf        <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && m_axis_output_tready) out_valid <= 1'b0;
      if (fire) begin
        acc <= acc_next;
        if (last_sf) begin
          out_data  <= OUT_BITS'(acc_next);
          out_valid <= 1'b1;
          sf        <= '0;
          nf        <= last_nf ? '0 : nf + NF_W'(1);
        end else begin
          sf <= sf + SF_W'(1);
        end
      end
    end
  end

  // Activation vector captured on the nf=0 pass and replayed for the remaining row folds.
  always_ff @(posedge ap_clk) begin
    if (fire && use_stream && (IS_MVU != 0)) act_buf[sf] <= s_axis_input_tdata[BUF_BITS-1:0];
  end

  assign m_axis_output_tdata  = out_data;
  assign m_axis_output_tvalid = out_valid;

endmodule

// File: tb/tb_mvu_vvu_axis.sv
// Scoreboard bench for mvu_vvu_axis: default signed instance plus an unsigned-activation instance.
module tb_mvu_vvu_axis;
  localparam int unsigned MW = 96, MH = 32, SIMD = 48, PE = 16;
  localparam int unsigned AW = 4, WW = 4, ACCW = 15;
  localparam int unsigned SF = MW / SIMD, NF = MH / PE;
  localparam int unsigned WB = PE*SIMD*WW, IB = SIMD*AW, OB = 240;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [WB-1:0] w_data = '0;
  logic          w_valid = 1'b0, w_ready;
  logic [IB-1:0] i_data = '0;
  logic          i_valid = 1'b0, i_ready;
  logic [OB-1:0] o_data;
  logic          o_valid, o_ready = 1'b0;

  logic [WB-1:0] u_w_data = '0;
  logic          u_w_valid = 1'b0, u_w_ready;
  logic [IB-1:0] u_i_data = '0;
  logic          u_i_valid = 1'b0, u_i_ready;
  logic [OB-1:0] u_o_data;
  logic          u_o_valid, u_o_ready = 1'b0;

  mvu_vvu_axis dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_weights_tdata(w_data), .s_axis_weights_tvalid(w_valid), .s_axis_weights_tready(w_ready),
    .s_axis_input_tdata(i_data), .s_axis_input_tvalid(i_valid), .s_axis_input_tready(i_ready),
    .m_axis_output_tdata(o_data), .m_axis_output_tvalid(o_valid), .m_axis_output_tready(o_ready)
  );

  mvu_vvu_axis #(.SIGNED_ACTIVATIONS(0)) dut_u (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_weights_tdata(u_w_data), .s_axis_weights_tvalid(u_w_valid), .s_axis_weights_tready(u_w_ready),
    .s_axis_input_tdata(u_i_data), .s_axis_input_tvalid(u_i_valid), .s_axis_input_tready(u_i_ready),
    .m_axis_output_tdata(u_o_data), .m_axis_output_tvalid(u_o_valid), .m_axis_output_tready(u_o_ready)
  );

  int n_cmp = 0, n_bad = 0;
  logic [OB-1:0] exp_q [$];
  logic signed [AW-1:0] av [MW];
  logic signed [WW-1:0] wm [MH][MW];
  bit rand_gaps = 1'b1, rand_ready = 1'b1, hold_out = 1'b0;

  task automatic chk(input string tag, input logic [OB-1:0] got, input logic [OB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OB-1:0] model_beat(input int nf);
    logic [OB-1:0] r;
    int s;
    r = '0;
    for (int k = 0; k < int'(PE); k++) begin
      s = 0;
      for (int c = 0; c < int'(MW); c++) s += int'(av[c]) * int'(wm[nf*int'(PE)+k][c]);
      r[k*ACCW +: ACCW] = ACCW'(s);
    end
    return r;
  endfunction

  function automatic logic [OB-1:0] fill_beat(input int v);
    logic [OB-1:0] r;
    r = '0;
    for (int k = 0; k < int'(PE); k++) r[k*ACCW +: ACCW] = ACCW'(v);
    return r;
  endfunction

  function automatic logic [IB-1:0] act_beat(input int sf);
    logic [IB-1:0] b;
    for (int l = 0; l < int'(SIMD); l++) b[l*AW +: AW] = av[sf*int'(SIMD)+l];
    return b;
  endfunction

  function automatic logic [WB-1:0] w_beat(input int nf, input int sf);
    logic [WB-1:0] b;
    for (int p = 0; p < int'(PE); p++)
      for (int l = 0; l < int'(SIMD); l++)
        b[(p*int'(SIMD)+l)*WW +: WW] = wm[nf*int'(PE)+p][sf*int'(SIMD)+l];
    return b;
  endfunction

  task automatic randomize_vector();
    for (int c = 0; c < int'(MW); c++) av[c] = AW'($urandom());
    for (int r = 0; r < int'(MH); r++)
      for (int c = 0; c < int'(MW); c++) wm[r][c] = WW'($urandom_range(0, 14) - 7);
  endtask

  task automatic send_act(input logic [IB-1:0] d);
    bit hs;
    int guard;
    hs = 1'b0;
    guard = 0;
    while (rand_gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    i_data = d;
    i_valid = 1'b1;
    while (!hs && guard < 1000) begin
      @(negedge clk); hs = i_ready; @(posedge clk); #1; guard++;
    end
    i_valid = 1'b0;
    chk("act handshake", OB'(hs), OB'(1));
  endtask

  task automatic send_w(input logic [WB-1:0] d);
    bit hs;
    int guard;
    hs = 1'b0;
    guard = 0;
    while (rand_gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    w_data = d;
    w_valid = 1'b1;
    while (!hs && guard < 1000) begin
      @(negedge clk); hs = w_ready; @(posedge clk); #1; guard++;
    end
    w_valid = 1'b0;
    chk("weight handshake", OB'(hs), OB'(1));
  endtask

  task automatic drive_vector();
    fork
      for (int s = 0; s < int'(SF); s++) send_act(act_beat(s));
      for (int n = 0; n < int'(NF); n++)
        for (int s = 0; s < int'(SF); s++) send_w(w_beat(n, s));
    join
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin @(posedge clk); g++; end
    #1;
    chk("drain", OB'(exp_q.size()), '0);
  endtask

  task automatic run_random();
    randomize_vector();
    for (int n = 0; n < int'(NF); n++) exp_q.push_back(model_beat(n));
    drive_vector();
    drain();
  endtask

  // Output sink: random or held-off tready, applied just after each rising edge.
  always @(posedge clk) begin
    #1;
    o_ready = hold_out ? 1'b0 : (rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
  end

  always @(negedge clk) begin
    if (o_valid && o_ready) begin
      if (exp_q.size() == 0) chk("unexpected beat", OB'(1), '0);
      else chk("out beat", o_data, exp_q.pop_front());
    end
  end

  initial begin
    logic [OB-1:0] snap;
    bit stable, rdy_low, seen;
    int g, cnt, got;

    // Reset: readies and valid stay low even with valid inputs presented.
    w_valid = 1'b1;
    i_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset tvalid/treadys", OB'({o_valid, i_ready, w_ready}), '0);
    chk("reset tdata", o_data, '0);
    w_valid = 1'b0;
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_random();
    run_random();

    // Extremes: most-negative activations against max positive weights.
    for (int c = 0; c < int'(MW); c++) av[c] = 4'h8;
    for (int r = 0; r < int'(MH); r++)
      for (int c = 0; c < int'(MW); c++) wm[r][c] = 4'sd7;
    for (int n = 0; n < int'(NF); n++) exp_q.push_back(fill_beat(-5376));
    drive_vector();
    drain();

    // Output backpressure for 20 cycles after the first tvalid.
    randomize_vector();
    for (int n = 0; n < int'(NF); n++) exp_q.push_back(model_beat(n));
    hold_out = 1'b1;
    fork
      drive_vector();
      begin
        g = 0;
        while (!o_valid && g < 500) begin @(negedge clk); g++; end
        chk("stall tvalid seen", OB'(o_valid), OB'(1));
        snap = o_data;
        stable = 1'b1;
        rdy_low = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (o_data !== snap || !o_valid) stable = 1'b0;
          if (i_ready || w_ready) rdy_low = 1'b0;
        end
        chk("stall data stable", OB'(stable), OB'(1));
        chk("stall treadys low", OB'(rdy_low), OB'(1));
        hold_out = 1'b0;
      end
    join
    drain();

    // Weights without activations must not be consumed beyond the pipeline.
    rand_gaps = 1'b0;
    w_data = WB'({$urandom(), $urandom()});
    w_valid = 1'b1;
    cnt = 0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (w_ready) cnt++;
      if (o_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    chk("weights-only accepted <= 1", OB'(cnt <= 1), OB'(1));
    chk("weights-only no output", OB'(seen), '0);

    // Mid-vector reset, then a clean vector with no leftover accumulation.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    randomize_vector();
    fork
      send_act(act_beat(0));
      send_w(w_beat(0, 0));
    join
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid-reset tvalid", OB'(o_valid), '0);
    chk("mid-reset tdata", o_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rand_gaps = 1'b1;
    run_random();

    // Unsigned activations 15 against weights -1.
    u_i_data = '1;
    u_w_data = '1;
    u_i_valid = 1'b1;
    u_w_valid = 1'b1;
    u_o_ready = 1'b1;
    got = 0;
    g = 0;
    while (got < 2 && g < 200) begin
      @(negedge clk);
      if (u_o_valid && u_o_ready) begin
        chk("unsigned beat", u_o_data, fill_beat(-1440));
        got++;
      end
      g++;
    end
    chk("unsigned beats seen", OB'(got), OB'(2));
    @(posedge clk); #1;
    u_i_valid = 1'b0;
    u_w_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mvu_vvu_axis.md
Name: mvu_vvu_axis

Overview:
- AXI-Stream matrix-vector (MVU) or vector-vector (VVU) unit for the FINN layer library.
- Consumes an activation vector in SF = MW/SIMD beats and a weight stream of NF*SF beats, where NF = MH/PE.
- Emits NF output beats, each carrying PE accumulated dot products.
- Sits between the input data-width converter/weight streamer and the thresholding stage.

Parameters:
- IS_MVU, 1, 1 = MVU: activations shared by all PEs. 0 = VVU: each PE has its own channel.
- COMPUTE_CORE, "mvu_4sx4u", selects the DSP/LUT core. Results must be numerically identical for every core.
- MW, 96, matrix width (columns); divisible by SIMD.
- MH, 32, matrix height (rows); divisible by PE.
- SIMD, 48, input lanes per beat.
- PE, 16, output lanes per beat.
- SEGMENTLEN, 2, DSP cascade segment length (timing only).
- FORCE_BEHAVIORAL, 0, 1 = use behavioural arithmetic instead of primitives.
- M_REG_LUT, 1, 1 = register multiplier outputs in LUT cores (timing only).
- ACTIVATION_WIDTH, 4, activation element bits.
- WEIGHT_WIDTH, 4, weight element bits (signed two's complement).
- ACCU_WIDTH, 15, accumulator/output lane bits.
- SIGNED_ACTIVATIONS, 1, 1 = activations signed, 0 = unsigned.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- s_axis_weights_tdata  in  ceil8(PE*SIMD*WEIGHT_WIDTH)  weight element [pe][simd] at bit offset (pe*SIMD+simd)*WEIGHT_WIDTH; pad bits ignored.
- s_axis_weights_tvalid  in  1.
- s_axis_weights_tready  out  1.
- s_axis_input_tdata  in  ceil8(SIMD*ACTIVATION_WIDTH) (MVU) or ceil8(PE*SIMD*ACTIVATION_WIDTH) (VVU)  lane l at offset l*ACTIVATION_WIDTH; pad bits ignored.
- s_axis_input_tvalid  in  1.
- s_axis_input_tready  out  1.
- m_axis_output_tdata  out  ceil8(PE*ACCU_WIDTH)  lane k at offset k*ACCU_WIDTH, signed; pad bits 0.
- m_axis_output_tvalid  out  1.
- m_axis_output_tready  in  1.

Behaviour:
- Reset (ap_rst_n=0, asynchronous):
  - all tvalid/tready outputs 0;
  - accumulators, fold counters (nf, sf) and activation buffer pointers cleared;
  - any in-flight partial result discarded.
  - First transfers are accepted in the first cycle after deassertion.
- A beat transfers on a rising edge when tvalid && tready. The DUT never drops an accepted beat and never duplicates one.
- Weight order: nf outer (0..NF-1), sf inner (0..SF-1).
- MVU activation handling:
  - During nf=0, activation beat sf is paired with weight beat (0,sf) and stored in an SF-entry buffer.
  - For nf>0, stored beats are replayed; s_axis_input_tready stays 0 until the last nf pass of the current vector has begun consuming.
  - The next vector is then accepted.
- VVU: one activation beat per weight beat, no replay. PE k uses input lanes [k*SIMD +: SIMD] (PE-major packing after untangling).
- Compute step fires only when the required weight beat and the required activation (stream or buffer) are both available and the pipeline is not stalled.
- Per step: acc[k] += sum over l of a[l]*w[k][l].
  - a is sign-extended if SIGNED_ACTIVATIONS, else zero-extended.
  - w is always signed.
- acc clears at sf=0. After sf=SF-1 the PE results form one output beat.
- Arithmetic is modulo 2^ACCU_WIDTH (wrap, no saturation).
- Weight value -2^(WEIGHT_WIDTH-1) is unsupported on packed DSP cores (behavioural path computes it exactly).
- Output:
  - Registered.
  - tdata is stable while tvalid && !tready.
  - When the output register is full and not accepted, the compute pipeline stalls and both input treadys drop.
- Latency from last contributing beat to tvalid: fixed pipeline depth, ≥1 cycle, independent of backpressure.
- Throughput: one compute step per cycle under no stalls.
- Boundary cases:
  - SF=1 and NF=1 are legal.
  - Weights arriving before activations wait; activations arriving early are buffered at most one beat beyond the current step.

Test Plan:
- Default config, random signed activations (96) and weights (32x96, no -8), random tvalid/tready → 2 output beats, every lane equal to the software dot product.
- All activations 0x8 (−8), all weights 7 → every lane = 96·(−56) = −5376 on both beats.
- SIGNED_ACTIVATIONS=0, activations 0xF (15), weights 0xF (−1) → every lane = −1440.
- m_axis_output_tready held 0 for 20 cycles after first tvalid → tdata stable, both treadys 0 during stall, no loss; both beats correct after release.
- Weights streamed with no activations → no output, s_axis_weights_tready stalls after at most pipeline depth beats.
- Assert ap_rst_n mid-vector, then rerun the default test → outputs 0/tvalid 0 during reset, subsequent results correct with no leftover accumulation.
